// File: rtl/arb_pkg.sv
// Shared constants and types for the arbitrating output multiplexer.
package arb_pkg;

    localparam logic PRIO_RR    = 1'b0;
    localparam logic PRIO_FIXED = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } lock_state_t;

endpackage

// File: rtl/arb_mux_if.sv
// Producer/consumer bundle: N request channels in, one registered beat stream out.
interface arb_mux_if #(
    parameter int N     = 3,
    parameter int WIDTH = 32,
    parameter int SELW  = $clog2(N)
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_last;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;

    // slave: the multiplexer; master: the surrounding producers and consumer
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_sel, out_last, out_valid
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_sel, out_last, out_valid
    );
endinterface

// File: rtl/arb_mux_rr_arbiter.sv
// Picks one requester: round-robin from ptr (wrapping) or lowest index first.
// Latency: purely combinational.
// Backpressure: none here; the caller qualifies the grant with its own load condition.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N    = 3,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            prio_mode,
    output logic [SELW-1:0] grant,
    output logic            any_grant
);

    logic [SELW-1:0] lo_idx;
    logic [SELW-1:0] hi_idx;
    logic            hi_found;

    // lo_idx: lowest requester overall; hi_idx: lowest requester at or above ptr.
    // Round-robin takes hi_idx and falls back to lo_idx, which is the wrap to 0.
    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        hi_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = SELW'(i);
                if (SELW'(i) >= ptr) begin
                    hi_idx   = SELW'(i);
                    hi_found = 1'b1;
                end
            end
        end
    end

    assign any_grant = |req;
    assign grant     = (prio_mode == PRIO_RR && hi_found) ? hi_idx : lo_idx;

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrating mux with grant locking for multi-beat transfers.
// Latency: a beat accepted in cycle t is on out_* in cycle t+1; one beat per cycle.
// Backpressure: out_valid & ~out_ready holds out_* and drops every in_ready.
module arb_mux
    import arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 3,
    parameter int SELW  = $clog2(N)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prio_mode,
    arb_mux_if.slave    bus
);

    lock_state_t     state, state_nxt;
    logic [SELW-1:0] lch, lch_nxt;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] grant;
    logic [N-1:0]    elig;
    logic            any_grant;
    logic            can_load;
    logic            load;
    logic            acc_last;
    logic [WIDTH-1:0] sel_data;

    // While locked only the owning channel may compete, whatever prio_mode says.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = bus.in_valid[i] & ((state == IDLE) | (SELW'(i) == lch));
        end
    end

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req       (elig),
        .ptr       (ptr),
        .prio_mode (prio_mode),
        .grant     (grant),
        .any_grant (any_grant)
    );

    assign can_load = ~bus.out_valid | bus.out_ready;
    assign load     = ~rst & can_load & any_grant;
    assign acc_last = bus.in_last[grant];
    assign sel_data = bus.in_data[int'(grant)*WIDTH +: WIDTH];

    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < N; i++) begin
            bus.in_ready[i] = load & (SELW'(i) == grant);
        end
    end

    always_comb begin
        state_nxt = state;
        lch_nxt   = lch;
        case (state)
            IDLE: begin
                if (load && !acc_last) begin
                    state_nxt = LOCK;
                    lch_nxt   = grant;
                end
            end
            LOCK: begin
                if (load && acc_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            lch   <= '0;
        end else begin
            state <= state_nxt;
            lch   <= lch_nxt;
        end
    end

    // Pointer only advances at the end of a transfer and only in round-robin mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (load && acc_last && prio_mode == PRIO_RR) begin
            ptr <= (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
            bus.out_last  <= 1'b0;
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= sel_data;
            bus.out_sel   <= grant;
            bus.out_last  <= acc_last;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux (N=3, WIDTH=5): reset, round-robin, fixed priority,
// lock, backpressure and reset in the middle of a locked transfer.
module tb_arb_mux;
    import arb_pkg::*;

    localparam int N  = 3;
    localparam int W  = 5;
    localparam int SW = 2;

    logic clk;
    logic rst;
    logic prio_mode;
    int   checks;
    int   failures;

    logic [W-1:0] tag [N];

    arb_mux_if #(.N(N), .WIDTH(W), .SELW(SW)) bus ();

    arb_mux #(
        .WIDTH (W),
        .N     (N),
        .SELW  (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .prio_mode (prio_mode),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic [W-1:0] d, input logic l);
        bus.in_valid[ch]       = v;
        bus.in_last[ch]        = l;
        bus.in_data[ch*W +: W] = d;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        tag[0]    = 5'h0A;
        tag[1]    = 5'h0B;
        tag[2]    = 5'h1F;
        rst       = 1'b1;
        prio_mode = PRIO_RR;
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.in_last   = '0;
        bus.out_ready = 1'b1;

        // reset values, with every channel requesting
        for (int i = 0; i < N; i++) set_ch(i, 1'b1, tag[i], 1'b1);
        step();
        step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data",  32'(bus.out_data),  32'h0);
        chk("rst_out_sel",   32'(bus.out_sel),   32'h0);
        chk("rst_out_last",  32'(bus.out_last),  32'h0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'h0);

        // round-robin fairness; channel 2 carries all-ones to check width
        rst = 1'b0;
        #1;
        chk("rr_first_ready", 32'(bus.in_ready), 32'h1);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_sel",   32'(bus.out_sel),   32'(k % 3));
            chk("rr_data",  32'(bus.out_data),  32'(tag[k % 3]));
            chk("rr_valid", 32'(bus.out_valid), 32'h1);
        end
        bus.in_valid = '0;
        step();
        chk("idle_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rr_ptr_wrap",    32'(dut.ptr),       32'h0);

        // fixed priority: 0 beats 2 until 0 drops
        prio_mode = PRIO_FIXED;
        set_ch(0, 1'b1, tag[0], 1'b1);
        set_ch(2, 1'b1, tag[2], 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("fp_sel0", 32'(bus.out_sel), 32'h0);
        end
        set_ch(0, 1'b0, tag[0], 1'b1);
        step();
        chk("fp_sel2",  32'(bus.out_sel),  32'h2);
        chk("fp_data2", 32'(bus.out_data), 32'h1F);
        bus.in_valid = '0;
        prio_mode    = PRIO_RR;
        step();
        chk("fp_drain",    32'(bus.out_valid), 32'h0);
        chk("fp_ptr_hold", 32'(dut.ptr),       32'h0);

        // lock: advance ptr to 1, then channel 1 sends three beats while 0 waits
        set_ch(0, 1'b1, tag[0], 1'b1);
        step();
        chk("lk_pre_sel", 32'(bus.out_sel), 32'h0);
        set_ch(1, 1'b1, 5'h11, 1'b0);
        #1;
        chk("lk_ready_b1", 32'(bus.in_ready), 32'h2);
        step();
        chk("lk_sel_b1",  32'(bus.out_sel),  32'h1);
        chk("lk_data_b1", 32'(bus.out_data), 32'h11);
        chk("lk_last_b1", 32'(bus.out_last), 32'h0);
        prio_mode = PRIO_FIXED;
        set_ch(1, 1'b1, 5'h12, 1'b0);
        #1;
        chk("lk_ready_b2", 32'(bus.in_ready), 32'h2);
        step();
        chk("lk_sel_b2",  32'(bus.out_sel),  32'h1);
        chk("lk_data_b2", 32'(bus.out_data), 32'h12);
        prio_mode = PRIO_RR;
        set_ch(1, 1'b1, 5'h13, 1'b1);
        #1;
        chk("lk_ready_b3", 32'(bus.in_ready), 32'h2);
        step();
        chk("lk_sel_b3",  32'(bus.out_sel),  32'h1);
        chk("lk_data_b3", 32'(bus.out_data), 32'h13);
        chk("lk_last_b3", 32'(bus.out_last), 32'h1);
        set_ch(1, 1'b1, 5'h14, 1'b1);
        set_ch(2, 1'b1, tag[2], 1'b1);
        step();
        chk("lk_after_sel2", 32'(bus.out_sel), 32'h2);
        step();
        chk("lk_after_sel0", 32'(bus.out_sel), 32'h0);
        step();
        chk("lk_after_sel1", 32'(bus.out_sel),  32'h1);
        chk("lk_after_dat1", 32'(bus.out_data), 32'h14);
        bus.in_valid = '0;
        step();
        chk("lk_drain", 32'(bus.out_valid), 32'h0);

        // backpressure with a single requester on channel 2
        bus.out_ready = 1'b0;
        set_ch(2, 1'b1, 5'h15, 1'b1);
        step();
        chk("bp_load_sel",  32'(bus.out_sel),  32'h2);
        chk("bp_load_data", 32'(bus.out_data), 32'h15);
        set_ch(2, 1'b1, 5'h16, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
            step();
            chk("bp_hold_data",  32'(bus.out_data),  32'h15);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'h1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'h4);
        step();
        chk("bp_next_data",  32'(bus.out_data),  32'h16);
        chk("bp_next_valid", 32'(bus.out_valid), 32'h1);
        bus.in_valid = '0;
        step();
        chk("bp_drain", 32'(bus.out_valid), 32'h0);

        // reset in the middle of a locked transfer
        set_ch(1, 1'b1, 5'h01, 1'b0);
        step();
        chk("rml_sel",        32'(bus.out_sel), 32'h1);
        chk("rml_state_lock", 32'(dut.state),   32'(LOCK));
        set_ch(1, 1'b1, 5'h02, 1'b0);
        rst = 1'b1;
        step();
        chk("rml_out_valid",  32'(bus.out_valid), 32'h0);
        chk("rml_state_idle", 32'(dut.state),     32'(IDLE));
        chk("rml_in_ready",   32'(bus.in_ready),  32'h0);
        rst = 1'b0;
        set_ch(1, 1'b0, 5'h02, 1'b0);
        set_ch(2, 1'b1, 5'h07, 1'b1);
        #1;
        chk("rml_ch2_ready", 32'(bus.in_ready), 32'h4);
        step();
        chk("rml_ch2_sel",   32'(bus.out_sel),   32'h2);
        chk("rml_ch2_data",  32'(bus.out_data),  32'h07);
        chk("rml_ch2_valid", 32'(bus.out_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
